// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and default widths for the round-robin register bank arbiter.
package reg_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 2;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bus of the register bank arbiter: flattened per-requester request lanes plus results.
interface reg_bank_arbiter_if
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
);
    localparam int NREG = 2 ** AW;

    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic [DW-1:0]        rdata;
    logic                 busy;
    logic [NREG*DW-1:0]   reg_out;

    modport master (
        output req, we, addr, wdata,
        input  gnt, ack, rdata, busy, reg_out
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, ack, rdata, busy, reg_out
    );

endinterface

// File: rtl/reg_bank_arbiter_bank_reg8.sv
// One datapath register of the bank: cleared by reset, loaded when selected by the arbiter.
module bank_reg8
    import reg_bank_arbiter_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters one read or write per grant into a bank of registers.
//   state  | meaning
//   IDLE   | waiting for any req; picks winner searching upward from ptr
//   ACCESS | winner latched; does the read/write if its req is still held, else aborts
//   DONE   | ack pulse to winner; ptr moves just past the winner
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic               clock,
    input  logic               reset,
    reg_bank_arbiter_if.slave  bus
);

    localparam int NREG = 2 ** AW;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state, state_nx;
    logic [PW-1:0]     ptr, win, pick;
    logic              lat_we;
    logic [AW-1:0]     lat_addr;
    logic [DW-1:0]     lat_wdata;
    logic [NREQ-1:0]   gnt_q, ack_q, gnt_d, ack_d;
    logic [DW-1:0]     rdata_q;
    logic              grab, bank_we, rd_load, ptr_adv;
    logic [DW-1:0]     reg_q [NREG];
    logic [NREG*DW-1:0] reg_flat;

    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] w;
        logic          hit;
        int            idx;
        w   = p;
        hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!hit && r[idx]) begin
                w   = PW'(idx);
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    assign pick = rr_pick(bus.req, ptr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            ptr       <= '0;
            win       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nx;
            gnt_q <= gnt_d;
            ack_q <= ack_d;
            if (grab) begin
                win       <= pick;
                lat_we    <= bus.we[pick];
                lat_addr  <= bus.addr[pick*AW +: AW];
                lat_wdata <= bus.wdata[pick*DW +: DW];
            end
            if (rd_load)
                rdata_q <= reg_q[lat_addr];
            if (ptr_adv)
                ptr <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|bus.req) state_nx = ACCESS;
            ACCESS:  state_nx = bus.req[win] ? DONE : IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // gnt is held through DONE by copying it forward; ack reuses the same one-hot
    always_comb begin
        gnt_d   = '0;
        ack_d   = '0;
        grab    = 1'b0;
        bank_we = 1'b0;
        rd_load = 1'b0;
        ptr_adv = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    grab  = 1'b1;
                    gnt_d = NREQ'(1) << pick;
                end
            end
            ACCESS: begin
                if (bus.req[win]) begin
                    gnt_d   = gnt_q;
                    ack_d   = gnt_q;
                    bank_we = lat_we;
                    rd_load = !lat_we;
                end
            end
            DONE:    ptr_adv = 1'b1;
            default: ;
        endcase
    end

    for (genvar k = 0; k < NREG; k++) begin : g_bank
        bank_reg8 #(.DW(DW)) u_reg (
            .clock (clock),
            .reset (reset),
            .load  (bank_we && (lat_addr == AW'(k))),
            .d     (lat_wdata),
            .q     (reg_q[k])
        );
    end

    always_comb begin
        reg_flat = '0;
        for (int k = 0; k < NREG; k++)
            reg_flat[k*DW +: DW] = reg_q[k];
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = (state != IDLE);
    assign bus.reg_out = reg_flat;

endmodule
